// File: rtl/timekeeper_multi_alarm_if.sv
// Control/status bundle between the button debouncers, the timekeeping core
// and the clock-face renderer / buzzer pad.
interface timekeeper_multi_alarm_if #(
    parameter int N_ALARMS = 2
);
    logic                mode_24h;
    logic                inc_sec;
    logic                inc_min;
    logic                inc_hour;
    logic [2:0]          al_sel;
    logic                al_inc_min;
    logic                al_inc_hour;
    logic                al_toggle;
    logic                snooze;
    logic                dismiss;
    logic [4:0]          hours;
    logic [5:0]          minutes;
    logic [5:0]          seconds;
    logic [4:0]          al_hours;
    logic [5:0]          al_minutes;
    logic [N_ALARMS-1:0] al_enabled;
    logic [N_ALARMS-1:0] ringing;
    logic [N_ALARMS-1:0] snoozing;
    logic                sec_tick;
    logic                half_sec;
    logic                buzzer;

    modport master (
        output mode_24h, inc_sec, inc_min, inc_hour, al_sel,
               al_inc_min, al_inc_hour, al_toggle, snooze, dismiss,
        input  hours, minutes, seconds, al_hours, al_minutes,
               al_enabled, ringing, snoozing, sec_tick, half_sec, buzzer
    );

    modport slave (
        input  mode_24h, inc_sec, inc_min, inc_hour, al_sel,
               al_inc_min, al_inc_hour, al_toggle, snooze, dismiss,
        output hours, minutes, seconds, al_hours, al_minutes,
               al_enabled, ringing, snoozing, sec_tick, half_sec, buzzer
    );
endinterface

// File: rtl/timekeeper_multi_alarm.sv
// 24-hour timekeeping core with N alarms (ring/snooze/auto-timeout),
// 12/24-hour output mapping and a gated buzzer tone.
module timekeeper_multi_alarm #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int N_ALARMS    = 2,
    parameter int TONE_DIV    = 7000,
    parameter int AL_STEP_MIN = 10,
    parameter int SNOOZE_MIN  = 5,
    parameter int RING_SEC    = 60
) (
    input  logic                    clk,
    input  logic                    reset,
    timekeeper_multi_alarm_if.slave bus
);
    localparam int PW         = $clog2(CLK_HZ);
    localparam int TW         = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int CNT_MAX    = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
    localparam int CW         = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

    logic [PW-1:0]       r_p;
    logic [TW-1:0]       r_tone_cnt;
    logic                r_tone;
    logic                r_sec_tick;
    logic [4:0]          r_h;
    logic [5:0]          r_m;
    logic [5:0]          r_s;
    logic [4:0]          r_al_h [N_ALARMS];
    logic [5:0]          r_al_m [N_ALARMS];
    logic [N_ALARMS-1:0] r_al_en;
    state_t              r_state [N_ALARMS];
    logic [CW-1:0]       r_cnt [N_ALARMS];

    logic                w_tick;
    logic [4:0]          w_h_nx;
    logic [5:0]          w_m_nx;
    logic [5:0]          w_s_nx;
    logic [N_ALARMS-1:0] w_al_en_nx;
    state_t              w_state_nx [N_ALARMS];
    logic [CW-1:0]       w_cnt_nx [N_ALARMS];
    logic [4:0]          w_rb_h;
    logic [5:0]          w_rb_m;
    logic [N_ALARMS-1:0] w_ringing;
    logic [N_ALARMS-1:0] w_snoozing;

    function automatic logic [4:0] map_hours(input logic [4:0] h, input logic m24);
        return (m24 || (h < 5'd12)) ? h : h - 5'd12;
    endfunction

    assign w_tick = (r_p == PW'(CLK_HZ - 1));

    // Tick carry chain is resolved first; manual increments then wrap the
    // already-carried field without propagating further.
    always_comb begin
        w_s_nx = r_s;
        w_m_nx = r_m;
        w_h_nx = r_h;
        if (w_tick) begin
            w_s_nx = (r_s == 6'd59) ? '0 : r_s + 6'd1;
            if (r_s == 6'd59) begin
                w_m_nx = (r_m == 6'd59) ? '0 : r_m + 6'd1;
                if (r_m == 6'd59)
                    w_h_nx = (r_h == 5'd23) ? '0 : r_h + 5'd1;
            end
        end
        if (bus.inc_sec)  w_s_nx = (w_s_nx == 6'd59) ? '0 : w_s_nx + 6'd1;
        if (bus.inc_min)  w_m_nx = (w_m_nx == 6'd59) ? '0 : w_m_nx + 6'd1;
        if (bus.inc_hour) w_h_nx = (w_h_nx == 5'd23) ? '0 : w_h_nx + 5'd1;
    end

    always_comb begin
        w_al_en_nx = r_al_en;
        for (int unsigned i = 0; i < N_ALARMS; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            if (bus.al_toggle && (bus.al_sel == 3'(i)) && r_al_en[i]) begin
                w_state_nx[i] = ST_IDLE;
                w_cnt_nx[i]   = '0;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_tick && r_al_en[i] && (w_h_nx == r_al_h[i]) &&
                            (w_m_nx == r_al_m[i]) && (w_s_nx == '0)) begin
                            w_state_nx[i] = ST_RING;
                            w_cnt_nx[i]   = CW'(RING_SEC);
                        end
                    end
                    ST_RING: begin
                        if (bus.dismiss) begin
                            w_state_nx[i] = ST_IDLE;
                            w_cnt_nx[i]   = '0;
                        end else if (bus.snooze) begin
                            w_state_nx[i] = ST_SNOOZE;
                            w_cnt_nx[i]   = CW'(SNOOZE_SEC);
                        end else if (w_tick) begin
                            w_cnt_nx[i] = r_cnt[i] - CW'(1);
                            if (r_cnt[i] == CW'(1))
                                w_state_nx[i] = ST_IDLE;
                        end
                    end
                    ST_SNOOZE: begin
                        if (bus.dismiss) begin
                            w_state_nx[i] = ST_IDLE;
                            w_cnt_nx[i]   = '0;
                        end else if (w_tick) begin
                            w_cnt_nx[i] = r_cnt[i] - CW'(1);
                            if (r_cnt[i] == CW'(1)) begin
                                w_state_nx[i] = ST_RING;
                                w_cnt_nx[i]   = CW'(RING_SEC);
                            end
                        end
                    end
                    default: begin
                        w_state_nx[i] = ST_IDLE;
                        w_cnt_nx[i]   = '0;
                    end
                endcase
            end
            if (bus.al_toggle && (bus.al_sel == 3'(i)))
                w_al_en_nx[i] = ~r_al_en[i];
        end
    end

    always_comb begin
        w_rb_h     = '0;
        w_rb_m     = '0;
        w_ringing  = '0;
        w_snoozing = '0;
        for (int unsigned i = 0; i < N_ALARMS; i++) begin
            if (bus.al_sel == 3'(i)) begin
                w_rb_h = r_al_h[i];
                w_rb_m = r_al_m[i];
            end
            w_ringing[i]  = (r_state[i] == ST_RING);
            w_snoozing[i] = (r_state[i] == ST_SNOOZE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p        <= '0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
            r_sec_tick <= 1'b0;
            r_h        <= '0;
            r_m        <= '0;
            r_s        <= '0;
            r_al_en    <= '0;
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
                r_al_h[i]  <= '0;
                r_al_m[i]  <= '0;
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_p        <= w_tick ? '0 : r_p + PW'(1);
            r_sec_tick <= w_tick;
            if (r_tone_cnt == TW'(TONE_DIV - 1)) begin
                r_tone_cnt <= '0;
                r_tone     <= ~r_tone;
            end else begin
                r_tone_cnt <= r_tone_cnt + TW'(1);
            end
            r_h     <= w_h_nx;
            r_m     <= w_m_nx;
            r_s     <= w_s_nx;
            r_al_en <= w_al_en_nx;
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                if (bus.al_sel == 3'(i)) begin
                    if (bus.al_inc_min)
                        r_al_m[i] <= (r_al_m[i] >= 6'(60 - AL_STEP_MIN)) ?
                                     r_al_m[i] - 6'(60 - AL_STEP_MIN) :
                                     r_al_m[i] + 6'(AL_STEP_MIN);
                    if (bus.al_inc_hour)
                        r_al_h[i] <= (r_al_h[i] == 5'd23) ? '0 : r_al_h[i] + 5'd1;
                end
            end
        end
    end

    assign bus.hours      = map_hours(r_h, bus.mode_24h);
    assign bus.minutes    = r_m;
    assign bus.seconds    = r_s;
    assign bus.al_hours   = map_hours(w_rb_h, bus.mode_24h);
    assign bus.al_minutes = w_rb_m;
    assign bus.al_enabled = r_al_en;
    assign bus.ringing    = w_ringing;
    assign bus.snoozing   = w_snoozing;
    assign bus.sec_tick   = r_sec_tick;
    assign bus.half_sec   = (r_p < PW'(CLK_HZ / 2));
    assign bus.buzzer     = (|w_ringing) & bus.half_sec & r_tone;
endmodule

// File: tb/tb_timekeeper_multi_alarm.sv
// Directed plus randomized bench for timekeeper_multi_alarm, checked every
// cycle against a time-of-day-in-seconds reference model.
module tb_timekeeper_multi_alarm;
    localparam int CLK_HZ   = 10;
    localparam int N        = 2;
    localparam int TONE_DIV = 2;
    localparam int STEP     = 10;
    localparam int SNZ_MIN  = 1;
    localparam int RING     = 3;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    timekeeper_multi_alarm_if #(.N_ALARMS(N)) bus ();

    timekeeper_multi_alarm #(
        .CLK_HZ(CLK_HZ), .N_ALARMS(N), .TONE_DIV(TONE_DIV),
        .AL_STEP_MIN(STEP), .SNOOZE_MIN(SNZ_MIN), .RING_SEC(RING)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: time as seconds of day, alarms as minutes of day,
    // alarm state 0=idle 1=ring 2=snooze
    int m_p, m_tod, m_tc, m_tone, m_tick;
    int m_am [N];
    int m_en [N];
    int m_st [N];
    int m_cnt [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic model_step();
        int h, mi, s, tick;
        if (reset) begin
            m_p = 0; m_tod = 0; m_tc = 0; m_tone = 0; m_tick = 0;
            for (int i = 0; i < N; i++) begin
                m_am[i] = 0; m_en[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
            end
            return;
        end
        tick = (m_p == CLK_HZ - 1);
        m_p  = tick ? 0 : m_p + 1;
        if (m_tc == TONE_DIV - 1) begin
            m_tc = 0;
            m_tone = !m_tone;
        end else begin
            m_tc++;
        end
        if (tick) m_tod = (m_tod + 1) % 86400;
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        if (bus.inc_sec)  s  = (s + 1) % 60;
        if (bus.inc_min)  mi = (mi + 1) % 60;
        if (bus.inc_hour) h  = (h + 1) % 24;
        m_tod = h * 3600 + mi * 60 + s;
        for (int i = 0; i < N; i++) begin
            if (bus.al_toggle && int'(bus.al_sel) == i && m_en[i] != 0) begin
                m_st[i] = 0;
            end else if (m_st[i] == 1) begin
                if (bus.dismiss) m_st[i] = 0;
                else if (bus.snooze) begin m_st[i] = 2; m_cnt[i] = SNZ_MIN * 60; end
                else if (tick) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) m_st[i] = 0;
                end
            end else if (m_st[i] == 2) begin
                if (bus.dismiss) m_st[i] = 0;
                else if (tick) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin m_st[i] = 1; m_cnt[i] = RING; end
                end
            end else if (tick && m_en[i] != 0 && m_tod == m_am[i] * 60) begin
                m_st[i] = 1;
                m_cnt[i] = RING;
            end
            if (int'(bus.al_sel) == i) begin
                if (bus.al_toggle) m_en[i] = (m_en[i] == 0);
                if (bus.al_inc_min)
                    m_am[i] = (m_am[i] / 60) * 60 + (m_am[i] % 60 + STEP) % 60;
                if (bus.al_inc_hour)
                    m_am[i] = ((m_am[i] / 60 + 1) % 24) * 60 + m_am[i] % 60;
            end
        end
        m_tick = tick;
    endtask

    task automatic check_all();
        int h, sel, a, half;
        logic [N-1:0] en_v, rg_v, sz_v;
        h = m_tod / 3600;
        chk("hours", bus.hours, bus.mode_24h ? h : h % 12);
        chk("minutes", bus.minutes, (m_tod / 60) % 60);
        chk("seconds", bus.seconds, m_tod % 60);
        chk("sec_tick", bus.sec_tick, m_tick);
        half = (m_p < CLK_HZ / 2);
        chk("half_sec", bus.half_sec, half);
        sel = int'(bus.al_sel);
        a = (sel < N) ? m_am[sel] : 0;
        chk("al_hours", bus.al_hours, bus.mode_24h ? a / 60 : (a / 60) % 12);
        chk("al_minutes", bus.al_minutes, a % 60);
        for (int i = 0; i < N; i++) begin
            en_v[i] = (m_en[i] != 0);
            rg_v[i] = (m_st[i] == 1);
            sz_v[i] = (m_st[i] == 2);
        end
        chk("al_enabled", bus.al_enabled, en_v);
        chk("ringing", bus.ringing, rg_v);
        chk("snoozing", bus.snoozing, sz_v);
        chk("buzzer", bus.buzzer, ((rg_v != 0) && half != 0 && m_tone != 0) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        bus.inc_sec = 0; bus.inc_min = 0; bus.inc_hour = 0;
        bus.al_inc_min = 0; bus.al_inc_hour = 0; bus.al_toggle = 0;
        bus.snooze = 0; bus.dismiss = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    // hours/minutes first, seconds only after they match, never on a tick edge
    task automatic set_time(input int th, input int tm, input int ts);
        int h, mi, s;
        for (int k = 0; k < 800; k++) begin
            h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
            if (h == th && mi == tm && s == ts) return;
            if (m_p != CLK_HZ - 1) begin
                bus.inc_hour = (h != th);
                bus.inc_min  = (mi != tm);
                bus.inc_sec  = (h == th && mi == tm && s != ts);
            end
            cycle();
        end
        timeout("set_time");
    endtask

    task automatic wait_ring(input int i);
        for (int k = 0; k < 300; k++) begin
            if (m_st[i] == 1) return;
            cycle();
        end
        timeout("wait_ring");
    endtask

    initial begin
        int m0, h0, cnt, done;
        reset = 1;
        bus.mode_24h = 1; bus.al_sel = 0;
        bus.inc_sec = 0; bus.inc_min = 0; bus.inc_hour = 0;
        bus.al_inc_min = 0; bus.al_inc_hour = 0; bus.al_toggle = 0;
        bus.snooze = 0; bus.dismiss = 0;
        do_reset();
        chk("rst_hours", bus.hours, 0);
        chk("rst_seconds", bus.seconds, 0);
        chk("rst_half_sec", bus.half_sec, 1);
        chk("rst_sec_tick", bus.sec_tick, 0);

        // first sec_tick exactly CLK_HZ cycles after release
        for (int k = 1; k <= CLK_HZ; k++) cycle();
        chk("first_tick", bus.sec_tick, 1);

        // mode mapping
        for (int k = 0; k < 13; k++) begin bus.inc_hour = 1; cycle(); end
        bus.mode_24h = 0; cycle();
        chk("mode12_hours", bus.hours, 1);
        bus.mode_24h = 1; cycle();
        chk("mode24_hours", bus.hours, 13);

        // tick carry and inc_sec on the same edge
        done = 0;
        for (int k = 0; k < 300 && done == 0; k++) begin
            if (m_p == CLK_HZ - 1 && m_tod % 60 == 59) done = 1;
            else begin
                if (m_tod % 60 != 59 && m_p != CLK_HZ - 1) bus.inc_sec = 1;
                cycle();
            end
        end
        if (done == 0) timeout("coll_sec_setup");
        m0 = (m_tod / 60) % 60;
        bus.inc_sec = 1; cycle();
        chk("coll_seconds", bus.seconds, 1);
        chk("coll_minutes", bus.minutes, (m0 + 1) % 60);

        // inc_min at 59 wraps without touching hours
        done = 0;
        for (int k = 0; k < 300 && done == 0; k++) begin
            if ((m_tod / 60) % 60 == 59 && m_p != CLK_HZ - 1 && m_tod % 60 != 59) done = 1;
            else begin
                if ((m_tod / 60) % 60 != 59 && m_p != CLK_HZ - 1) bus.inc_min = 1;
                cycle();
            end
        end
        if (done == 0) timeout("coll_min_setup");
        h0 = m_tod / 3600;
        bus.inc_min = 1; cycle();
        chk("wrap_minutes", bus.minutes, 0);
        chk("wrap_hours", bus.hours, h0);

        // day rollover
        set_time(23, 59, 55);
        done = 0;
        for (int k = 0; k < 200 && done == 0; k++) begin
            cycle();
            if (bus.sec_tick === 1'b1 && bus.hours === 5'd0) done = 1;
        end
        if (done == 0) timeout("rollover");
        chk("roll_hours", bus.hours, 0);
        chk("roll_minutes", bus.minutes, 0);
        chk("roll_seconds", bus.seconds, 0);

        // alarm 0 at 0:10, ring then auto-stop after RING ticks
        do_reset();
        bus.al_sel = 0; bus.al_inc_min = 1; cycle();
        chk("al_set_min", bus.al_minutes, 10);
        bus.al_toggle = 1; cycle();
        set_time(0, 9, 55);
        wait_ring(0);
        chk("ring_rise", bus.ringing[0], 1);
        chk("ring_minutes", bus.minutes, 10);
        chk("ring_seconds", bus.seconds, 0);
        cnt = 0;
        for (int k = 0; k < 100 && bus.ringing[0] === 1'b1; k++) begin
            cycle();
            if (bus.sec_tick === 1'b1) cnt++;
        end
        chk("ring_ticks", cnt, RING);

        // snooze, re-ring, dismiss in snooze
        bus.al_inc_min = 1; cycle();
        set_time(0, 19, 55);
        wait_ring(0);
        bus.snooze = 1; cycle();
        chk("snz_snoozing", bus.snoozing[0], 1);
        chk("snz_ringing", bus.ringing[0], 0);
        chk("snz_buzzer", bus.buzzer, 0);
        cnt = 0;
        for (int k = 0; k < 800 && bus.ringing[0] !== 1'b1; k++) begin
            cycle();
            if (bus.sec_tick === 1'b1) cnt++;
        end
        chk("snooze_ticks", cnt, SNZ_MIN * 60);
        bus.snooze = 1; cycle();
        bus.dismiss = 1; cycle();
        chk("dis_snoozing", bus.snoozing[0], 0);
        chk("dis_ringing", bus.ringing[0], 0);

        // disable while ringing
        bus.al_inc_min = 1; cycle();
        set_time(0, 29, 55);
        wait_ring(0);
        bus.al_toggle = 1; cycle();
        chk("off_enabled", bus.al_enabled[0], 0);
        chk("off_ringing", bus.ringing[0], 0);
        chk("off_buzzer", bus.buzzer, 0);

        // two alarms at 0:40, one dismiss clears both
        bus.al_toggle = 1; bus.al_inc_min = 1; cycle();
        bus.al_sel = 1;
        for (int k = 0; k < 4; k++) begin bus.al_inc_min = 1; cycle(); end
        bus.al_toggle = 1; cycle();
        set_time(0, 39, 55);
        wait_ring(0);
        chk("multi_ring", bus.ringing, 2'b11);
        bus.dismiss = 1; cycle();
        chk("multi_dismiss", bus.ringing, 2'b00);

        // out-of-range select
        bus.al_sel = 5; bus.al_inc_min = 1; bus.al_inc_hour = 1; cycle();
        chk("oor_minutes", bus.al_minutes, 0);
        chk("oor_hours", bus.al_hours, 0);
        bus.al_sel = 1; cycle();
        chk("oor_untouched", bus.al_minutes, 40);

        // reset during snooze
        bus.al_sel = 0; bus.al_inc_min = 1; cycle();
        set_time(0, 49, 55);
        wait_ring(0);
        bus.snooze = 1; cycle();
        chk("pre_rst_snoozing", bus.snoozing[0], 1);
        reset = 1; cycle(); reset = 0;
        chk("rst_snoozing", bus.snoozing, 0);
        chk("rst_ringing", bus.ringing, 0);
        chk("rst_enabled", bus.al_enabled, 0);
        chk("rst_buzzer", bus.buzzer, 0);
        chk("rst_minutes", bus.minutes, 0);
        chk("rst_half_sec2", bus.half_sec, 1);

        // randomized traffic around midnight with both alarms armed at 0:00
        set_time(23, 59, 20);
        bus.al_sel = 0; bus.al_toggle = 1; cycle();
        bus.al_sel = 1; bus.al_toggle = 1; cycle();
        for (int k = 0; k < 3000; k++) begin
            bus.inc_sec     = ($urandom_range(59) == 0);
            bus.inc_min     = ($urandom_range(99) == 0);
            bus.inc_hour    = ($urandom_range(149) == 0);
            bus.al_inc_min  = ($urandom_range(149) == 0);
            bus.al_inc_hour = ($urandom_range(199) == 0);
            bus.al_toggle   = ($urandom_range(199) == 0);
            bus.snooze      = ($urandom_range(39) == 0);
            bus.dismiss     = ($urandom_range(79) == 0);
            if ($urandom_range(49) == 0) bus.mode_24h = ~bus.mode_24h;
            if ($urandom_range(19) == 0) bus.al_sel = 3'($urandom_range(7));
            reset = ($urandom_range(1499) == 0);
            cycle();
            reset = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
